// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the fetch/data memory request arbiter:
// FSM state encoding and port identifiers.
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// CPU-side fetch/data ports and the merged downstream request/response channel.
// The arbiter takes the slave view; the CPU and memory side take the master view.
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              Inst_Req_Valid;
  logic [ADDR_W-1:0] PC;
  logic              Inst_Req_Ready;
  logic [DATA_W-1:0] Instruction;
  logic              Inst_Valid;
  logic              Inst_Ready;

  logic [ADDR_W-1:0] Address;
  logic              MemWrite;
  logic [DATA_W-1:0] Write_data;
  logic [STRB_W-1:0] Write_strb;
  logic              MemRead;
  logic              Mem_Req_Ready;
  logic [DATA_W-1:0] Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ready;

  logic [ADDR_W-1:0] m_Address;
  logic              m_MemWrite;
  logic [DATA_W-1:0] m_Write_data;
  logic [STRB_W-1:0] m_Write_strb;
  logic              m_MemRead;
  logic              m_Mem_Req_Ready;
  logic [DATA_W-1:0] m_Read_data;
  logic              m_Read_data_Valid;
  logic              m_Read_data_Ready;

  modport slave (
    input  Inst_Req_Valid, PC, Inst_Ready,
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    input  m_Mem_Req_Ready, m_Read_data, m_Read_data_Valid,
    output Inst_Req_Ready, Instruction, Inst_Valid,
    output Mem_Req_Ready, Read_data, Read_data_Valid,
    output m_Address, m_MemWrite, m_Write_data, m_Write_strb, m_MemRead, m_Read_data_Ready
  );

  modport master (
    output Inst_Req_Valid, PC, Inst_Ready,
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ready,
    output m_Mem_Req_Ready, m_Read_data, m_Read_data_Valid,
    input  Inst_Req_Ready, Instruction, Inst_Valid,
    input  Mem_Req_Ready, Read_data, Read_data_Valid,
    input  m_Address, m_MemWrite, m_Write_data, m_Write_strb, m_MemRead, m_Read_data_Ready
  );

endinterface

// File: rtl/mem_req_arbiter_arb_rr2.sv
// Combinational two-requester grant: sole requester wins; on conflict either
// alternate away from the last grant (RR_EN != 0) or always favour the data port.
module arb_rr2
  import mem_req_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic req_inst,
  input  logic req_data,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  always_comb begin
    grant_valid = req_inst | req_data;
    grant       = DATA;
    if (req_inst && !req_data) begin
      grant = INST;
    end else if (req_inst && req_data && (RR_EN != 0)) begin
      grant = other_port(last_grant);
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges the instruction-fetch and data ports onto one downstream channel with a
// single outstanding transaction; read data is returned only to the issuing port.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic             cpu_clk,
  input  logic             cpu_reset,
  mem_req_arbiter_if.slave bus
);

  arb_state_e state, state_nxt;

  // last_grant doubles as the owner of the transaction in flight.
  logic last_grant;
  logic data_req;
  logic win_valid;
  logic win_port;
  logic take_grant;
  logic take_accept;
  logic port_ready;

  assign data_req = bus.MemRead | bus.MemWrite;

  arb_rr2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .req_inst   (bus.Inst_Req_Valid),
    .req_data   (data_req),
    .last_grant (last_grant),
    .grant_valid(win_valid),
    .grant      (win_port)
  );

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt             = state;
    take_grant            = 1'b0;
    take_accept           = 1'b0;
    port_ready            = (last_grant == INST) ? bus.Inst_Ready : bus.Read_data_Ready;
    bus.Inst_Req_Ready    = 1'b0;
    bus.Mem_Req_Ready     = 1'b0;
    bus.Inst_Valid        = 1'b0;
    bus.Read_data_Valid   = 1'b0;
    bus.m_Read_data_Ready = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          take_grant = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        if (bus.m_Mem_Req_Ready) begin
          take_accept        = 1'b1;
          bus.Inst_Req_Ready = (last_grant == INST);
          bus.Mem_Req_Ready  = (last_grant == DATA);
          // Writes retire at acceptance; only reads wait for a response.
          state_nxt          = bus.m_MemRead ? RESP : IDLE;
        end
      end
      RESP: begin
        bus.m_Read_data_Ready = port_ready;
        bus.Inst_Valid        = (last_grant == INST) & bus.m_Read_data_Valid;
        bus.Read_data_Valid   = (last_grant == DATA) & bus.m_Read_data_Valid;
        if (bus.m_Read_data_Valid && port_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Instruction = bus.Inst_Valid      ? bus.m_Read_data : '0;
  assign bus.Read_data   = bus.Read_data_Valid ? bus.m_Read_data : '0;

  always_ff @(posedge cpu_clk or posedge cpu_reset) begin
    if (cpu_reset) begin
      last_grant       <= INST;
      bus.m_Address    <= '0;
      bus.m_MemWrite   <= 1'b0;
      bus.m_Write_data <= '0;
      bus.m_Write_strb <= '0;
      bus.m_MemRead    <= 1'b0;
    end else if (take_grant) begin
      last_grant <= win_port;
      if (win_port == INST) begin
        bus.m_Address    <= bus.PC;
        bus.m_MemWrite   <= 1'b0;
        bus.m_Write_data <= '0;
        bus.m_Write_strb <= '0;
        bus.m_MemRead    <= 1'b1;
      end else begin
        bus.m_Address    <= bus.Address;
        bus.m_MemWrite   <= bus.MemWrite;
        bus.m_Write_data <= bus.Write_data;
        bus.m_Write_strb <= bus.Write_strb;
        bus.m_MemRead    <= bus.MemRead;
      end
    end else if (take_accept) begin
      bus.m_MemWrite <= 1'b0;
      bus.m_MemRead  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Random traffic on both CPU ports against a transaction-level arbitration and
// memory model, run on a round-robin and a fixed-priority instance in turn.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic cpu_clk   = 1'b0;
  logic cpu_reset = 1'b1;
  logic sel_rr    = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  logic          i_req, i_rdy, d_wr, d_rd, d_rdy, m_rdy, m_rvld;
  logic [AW-1:0] i_pc, d_addr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [SW-1:0] d_strb;

  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_rr ();
  mem_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_fp ();

  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1)) u_rr (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .bus(bus_rr));
  mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(0)) u_fp (
    .cpu_clk(cpu_clk), .cpu_reset(cpu_reset), .bus(bus_fp));

  // Only the selected instance sees traffic; the other idles.
  assign bus_rr.Inst_Req_Valid    = sel_rr & i_req;
  assign bus_rr.PC                = i_pc;
  assign bus_rr.Inst_Ready        = sel_rr & i_rdy;
  assign bus_rr.Address           = d_addr;
  assign bus_rr.MemWrite          = sel_rr & d_wr;
  assign bus_rr.Write_data        = d_wdata;
  assign bus_rr.Write_strb        = d_strb;
  assign bus_rr.MemRead           = sel_rr & d_rd;
  assign bus_rr.Read_data_Ready   = sel_rr & d_rdy;
  assign bus_rr.m_Mem_Req_Ready   = sel_rr & m_rdy;
  assign bus_rr.m_Read_data       = m_rdata;
  assign bus_rr.m_Read_data_Valid = sel_rr & m_rvld;

  assign bus_fp.Inst_Req_Valid    = !sel_rr & i_req;
  assign bus_fp.PC                = i_pc;
  assign bus_fp.Inst_Ready        = !sel_rr & i_rdy;
  assign bus_fp.Address           = d_addr;
  assign bus_fp.MemWrite          = !sel_rr & d_wr;
  assign bus_fp.Write_data        = d_wdata;
  assign bus_fp.Write_strb        = d_strb;
  assign bus_fp.MemRead           = !sel_rr & d_rd;
  assign bus_fp.Read_data_Ready   = !sel_rr & d_rdy;
  assign bus_fp.m_Mem_Req_Ready   = !sel_rr & m_rdy;
  assign bus_fp.m_Read_data       = m_rdata;
  assign bus_fp.m_Read_data_Valid = !sel_rr & m_rvld;

  wire          o_irr   = sel_rr ? bus_rr.Inst_Req_Ready    : bus_fp.Inst_Req_Ready;
  wire [DW-1:0] o_instr = sel_rr ? bus_rr.Instruction       : bus_fp.Instruction;
  wire          o_iv    = sel_rr ? bus_rr.Inst_Valid        : bus_fp.Inst_Valid;
  wire          o_mrr   = sel_rr ? bus_rr.Mem_Req_Ready     : bus_fp.Mem_Req_Ready;
  wire [DW-1:0] o_rdata = sel_rr ? bus_rr.Read_data         : bus_fp.Read_data;
  wire          o_dv    = sel_rr ? bus_rr.Read_data_Valid   : bus_fp.Read_data_Valid;
  wire [AW-1:0] o_maddr = sel_rr ? bus_rr.m_Address         : bus_fp.m_Address;
  wire          o_mwr   = sel_rr ? bus_rr.m_MemWrite        : bus_fp.m_MemWrite;
  wire [DW-1:0] o_mwd   = sel_rr ? bus_rr.m_Write_data      : bus_fp.m_Write_data;
  wire [SW-1:0] o_mstb  = sel_rr ? bus_rr.m_Write_strb      : bus_fp.m_Write_strb;
  wire          o_mrd   = sel_rr ? bus_rr.m_MemRead         : bus_fp.m_MemRead;
  wire          o_mrdr  = sel_rr ? bus_rr.m_Read_data_Ready : bus_fp.m_Read_data_Ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which port owns the channel and what it asked for.
  logic          mdl_free, mdl_out, mdl_resp, mdl_owner, mdl_last, exp_rd, exp_wr;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [SW-1:0] exp_strb;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            n_done;

  // Downstream memory as seen through the DUT's own m_* outputs.
  logic [DW-1:0] dut_mem [logic [AW-1:0]];
  logic          r_pend;
  logic [DW-1:0] r_data;
  int            r_wait;
  logic          i_acc, d_acc;
  int            grant_log [$];

  function automatic logic pct(input int p);
    return int'($urandom_range(0, 99)) < p;
  endfunction

  function automatic logic [DW-1:0] mem_seed(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] v;
    v = old;
    for (int b = 0; b < SW; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'(32'h100 + 4 * $urandom_range(0, 15));
  endfunction

  task automatic clear_drives();
    i_req = 0; i_rdy = 0; d_wr = 0; d_rd = 0; d_rdy = 0; m_rdy = 0; m_rvld = 0;
    i_pc = '0; d_addr = '0; d_wdata = '0; m_rdata = '0; d_strb = '0;
    i_acc = 0; d_acc = 0; r_pend = 0; r_wait = 0; r_data = '0;
  endtask

  task automatic model_reset();
    mdl_free = 1; mdl_out = 0; mdl_resp = 0; mdl_owner = INST; mdl_last = INST;
    exp_rd = 0; exp_wr = 0; exp_addr = '0; exp_wdata = '0; exp_strb = '0;
  endtask

  task automatic do_reset(input logic keep);
    @(posedge cpu_clk); #1;
    cpu_reset = 1'b1;
    if (!keep) clear_drives();
    @(negedge cpu_clk);
    chk("rst_Inst_Req_Ready", o_irr, 0);
    chk("rst_Instruction", o_instr, 0);
    chk("rst_Inst_Valid", o_iv, 0);
    chk("rst_Mem_Req_Ready", o_mrr, 0);
    chk("rst_Read_data", o_rdata, 0);
    chk("rst_Read_data_Valid", o_dv, 0);
    chk("rst_m_Address", o_maddr, 0);
    chk("rst_m_MemWrite", o_mwr, 0);
    chk("rst_m_Write_data", o_mwd, 0);
    chk("rst_m_Write_strb", o_mstb, 0);
    chk("rst_m_MemRead", o_mrd, 0);
    chk("rst_m_Read_data_Ready", o_mrdr, 0);
    clear_drives();
    model_reset();
    @(posedge cpu_clk); #1;
    cpu_reset = 1'b0;
  endtask

  task automatic step(input int p_req, input int p_rdy, input int p_mrdy);
    logic own_rdy, d_req, win;
    logic [AW-1:0] a;
    @(posedge cpu_clk); #1;
    if (i_acc) i_req = 1'b0;
    if (d_acc) begin d_wr = 1'b0; d_rd = 1'b0; end
    i_acc = 0; d_acc = 0;
    if (!i_req && pct(p_req)) begin i_req = 1; i_pc = rnd_addr(); end
    if (!d_wr && !d_rd && pct(p_req)) begin
      if ($urandom_range(0, 1) == 1) d_wr = 1; else d_rd = 1;
      d_addr = rnd_addr(); d_wdata = $urandom; d_strb = SW'($urandom_range(0, 15));
    end
    i_rdy = pct(p_rdy); d_rdy = pct(p_rdy); m_rdy = pct(p_mrdy);
    if (r_pend) begin
      if (r_wait > 0) begin r_wait--; m_rvld = 0; end
      else begin m_rvld = 1; m_rdata = r_data; end
    end else begin
      m_rvld = pct(10); m_rdata = $urandom;
    end

    @(negedge cpu_clk);
    own_rdy = (mdl_owner == INST) ? i_rdy : d_rdy;
    chk("m_MemRead", o_mrd, mdl_out & exp_rd);
    chk("m_MemWrite", o_mwr, mdl_out & exp_wr);
    if (mdl_out) begin
      chk("m_Address", o_maddr, exp_addr);
      chk("m_Write_strb", o_mstb, exp_strb);
      if (mdl_owner == DATA) chk("m_Write_data", o_mwd, exp_wdata);
    end
    chk("Inst_Req_Ready", o_irr, mdl_out && mdl_owner == INST && m_rdy);
    chk("Mem_Req_Ready", o_mrr, mdl_out && mdl_owner == DATA && m_rdy);
    chk("m_Read_data_Ready", o_mrdr, mdl_resp && own_rdy);
    chk("Inst_Valid", o_iv, mdl_resp && mdl_owner == INST && m_rvld);
    chk("Read_data_Valid", o_dv, mdl_resp && mdl_owner == DATA && m_rvld);
    chk("Instruction", o_instr, (mdl_resp && mdl_owner == INST && m_rvld) ? m_rdata : '0);
    chk("Read_data", o_rdata, (mdl_resp && mdl_owner == DATA && m_rvld) ? m_rdata : '0);
    if (mdl_resp && m_rvld && own_rdy) begin
      a = exp_addr;
      chk("rsp_value", (mdl_owner == INST) ? o_instr : o_rdata,
          ref_mem.exists(a) ? ref_mem[a] : mem_seed(a));
    end

    // environment reacts to what the DUT actually did
    if (o_irr) begin i_acc = 1; grant_log.push_back(0); end
    if (o_mrr) begin d_acc = 1; grant_log.push_back(1); end
    if (o_mwr && m_rdy) begin
      a = o_maddr;
      dut_mem[a] = merge(dut_mem.exists(a) ? dut_mem[a] : mem_seed(a), o_mwd, o_mstb);
    end
    if (r_pend && m_rvld && o_mrdr) r_pend = 0;
    if (o_mrd && m_rdy) begin
      a = o_maddr;
      r_pend = 1; r_wait = $urandom_range(0, 3);
      r_data = dut_mem.exists(a) ? dut_mem[a] : mem_seed(a);
    end

    // model advances across the coming edge
    d_req = d_wr | d_rd;
    if (mdl_free) begin
      if (i_req || d_req) begin
        if (i_req && d_req) win = sel_rr ? ~mdl_last : DATA;
        else win = d_req ? DATA : INST;
        mdl_free = 0; mdl_out = 1; mdl_owner = win; mdl_last = win;
        if (win == INST) begin
          exp_addr = i_pc; exp_rd = 1; exp_wr = 0; exp_strb = '0; exp_wdata = '0;
        end else begin
          exp_addr = d_addr; exp_rd = d_rd; exp_wr = d_wr; exp_strb = d_strb; exp_wdata = d_wdata;
        end
      end
    end else if (mdl_out) begin
      if (m_rdy) begin
        mdl_out = 0;
        if (exp_wr) begin
          ref_mem[exp_addr] = merge(ref_mem.exists(exp_addr) ? ref_mem[exp_addr]
                                    : mem_seed(exp_addr), exp_wdata, exp_strb);
        end
        if (exp_rd) mdl_resp = 1;
        else begin mdl_free = 1; n_done++; end
      end
    end else if (mdl_resp && m_rvld && own_rdy) begin
      mdl_resp = 0; mdl_free = 1; n_done++;
    end
  endtask

  initial begin
    clear_drives();
    model_reset();
    for (int s = 0; s < 2; s++) begin
      sel_rr = (s == 0);
      do_reset(1'b0);
      grant_log.delete();
      repeat (40) step(100, 100, 100);
      chk("grant_cnt", grant_log.size() >= 4, 1);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
        chk($sformatf("grant_order%0d_rr%0d", k, sel_rr), grant_log[k],
            (sel_rr && (k % 2 == 1)) ? 0 : 1);
      do_reset(1'b0);
      n_done = 0;
      repeat (1500) begin
        step(40, 60, 50);
        if (mdl_resp && $urandom_range(0, 39) == 0) do_reset(1'b1);
      end
      chk("traffic_done", n_done > 50, 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
